// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and load writeback paths.
// Port outputs are registered; writes aimed at register 0 are accepted but never enabled.
module regfile_write_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             req0_valid,
   input  logic [4:0]       req0_addr,
   input  logic [31:0]      req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [4:0]       req1_addr,
   input  logic [31:0]      req1_data,
   output logic             req1_ready,
   output logic             we3,
   output logic [4:0]       a3,
   output logic [31:0]      wd3,
   output logic             prio,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             grant0_s;
   logic             grant1_s;
   logic             we3_r;
   logic [4:0]       a3_r;
   logic [31:0]      wd3_r;
   logic             prio_r;
   logic [CNT_W-1:0] cnt0_r;
   logic [CNT_W-1:0] cnt1_r;

   // Saturating increment so debug counters stick at their maximum instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      if (val == CNT_MAX) begin
         sat_inc = val;
      end else begin
         sat_inc = val + CNT_ONE;
      end
   endfunction

   // Grant selection: single requester wins outright, a tie goes to the prio owner.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (reset || hold) begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end else if (req0_valid && req1_valid) begin
         grant0_s = ~prio_r;
         grant1_s = prio_r;
      end else if (req0_valid) begin
         grant0_s = 1'b1;
      end else if (req1_valid) begin
         grant1_s = 1'b1;
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // Write-port register, round-robin pointer and grant counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we3_r  <= 1'b0;
         a3_r   <= 5'd0;
         wd3_r  <= 32'd0;
         prio_r <= 1'b0;
         cnt0_r <= {CNT_W{1'b0}};
         cnt1_r <= {CNT_W{1'b0}};
      end else if (grant0_s) begin
         we3_r  <= (req0_addr != 5'd0);
         a3_r   <= req0_addr;
         wd3_r  <= req0_data;
         prio_r <= 1'b1;
         cnt0_r <= sat_inc(cnt0_r);
      end else if (grant1_s) begin
         we3_r  <= (req1_addr != 5'd0);
         a3_r   <= req1_addr;
         wd3_r  <= req1_data;
         prio_r <= 1'b0;
         cnt1_r <= sat_inc(cnt1_r);
      end else begin
         we3_r  <= 1'b0;
      end
   end

   assign req0_ready = grant0_s;
   assign req1_ready = grant1_s;
   assign we3        = we3_r;
   assign a3         = a3_r;
   assign wd3        = wd3_r;
   assign prio       = prio_r;
   assign grant_cnt0 = cnt0_r;
   assign grant_cnt1 = cnt1_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; a second CNT_W=2 instance exercises counter saturation.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        hold;
   logic        req0_valid;
   logic [4:0]  req0_addr;
   logic [31:0] req0_data;
   logic        req1_valid;
   logic [4:0]  req1_addr;
   logic [31:0] req1_data;

   logic        req0_ready, req1_ready, we3, prio;
   logic [4:0]  a3;
   logic [31:0] wd3;
   logic [15:0] grant_cnt0, grant_cnt1;

   logic        s_req0_ready, s_req1_ready, s_we3, s_prio;
   logic [4:0]  s_a3;
   logic [31:0] s_wd3;
   logic [1:0]  s_grant_cnt0, s_grant_cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .hold(hold),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .we3(we3), .a3(a3), .wd3(wd3), .prio(prio),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
   );

   regfile_write_arbiter #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .hold(hold),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(s_req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(s_req1_ready),
      .we3(s_we3), .a3(s_a3), .wd3(s_wd3), .prio(s_prio),
      .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; hold = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0;
      req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'h0;
      #3;
      check_val("rst_we3", {31'd0, we3}, 32'd0);
      check_val("rst_a3", {27'd0, a3}, 32'd0);
      check_val("rst_wd3", wd3, 32'd0);
      check_val("rst_prio", {31'd0, prio}, 32'd0);
      check_val("rst_cnt0", {16'd0, grant_cnt0}, 32'd0);
      check_val("rst_cnt1", {16'd0, grant_cnt1}, 32'd0);
      check_val("rst_ready0", {31'd0, req0_ready}, 32'd0);
      req0_valid = 1'b0;
      step();
      reset = 1'b0;

      // Single requester
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
      #1;
      check_val("single_ready0", {31'd0, req0_ready}, 32'd1);
      check_val("single_ready1", {31'd0, req1_ready}, 32'd0);
      step();
      req0_valid = 1'b0;
      check_val("single_we3", {31'd0, we3}, 32'd1);
      check_val("single_a3", {27'd0, a3}, 32'd5);
      check_val("single_wd3", wd3, 32'hDEADBEEF);
      check_val("single_cnt0", {16'd0, grant_cnt0}, 32'd1);
      check_val("single_prio", {31'd0, prio}, 32'd1);

      // Asynchronous reset while we3 is high
      #2;
      reset = 1'b1;
      #1;
      check_val("arst_we3", {31'd0, we3}, 32'd0);
      check_val("arst_a3", {27'd0, a3}, 32'd0);
      check_val("arst_wd3", wd3, 32'd0);
      check_val("arst_prio", {31'd0, prio}, 32'd0);
      step();
      reset = 1'b0;

      // Contention from prio=0: order 0,1,0,1
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h000000A0;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h000000B1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_val($sformatf("cont_ready0_%0d", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check_val($sformatf("cont_ready1_%0d", i), {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
         step();
         check_val($sformatf("cont_we3_%0d", i), {31'd0, we3}, 32'd1);
         check_val($sformatf("cont_a3_%0d", i), {27'd0, a3}, (i % 2 == 0) ? 32'd1 : 32'd2);
         check_val($sformatf("cont_wd3_%0d", i), wd3, (i % 2 == 0) ? 32'h000000A0 : 32'h000000B1);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check_val("cont_cnt0", {16'd0, grant_cnt0}, 32'd2);
      check_val("cont_cnt1", {16'd0, grant_cnt1}, 32'd2);
      check_val("cont_prio", {31'd0, prio}, 32'd0);
      step();
      check_val("idle_we3", {31'd0, we3}, 32'd0);
      check_val("idle_a3_hold", {27'd0, a3}, 32'd2);

      // Move prio to 1, then a register-0 write from req1 flips it back
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h00000077;
      step();
      req0_valid = 1'b0;
      check_val("pre_r0_prio", {31'd0, prio}, 32'd1);
      req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h12345678;
      #1;
      check_val("r0_ready1", {31'd0, req1_ready}, 32'd1);
      step();
      req1_valid = 1'b0;
      check_val("r0_we3", {31'd0, we3}, 32'd0);
      check_val("r0_a3", {27'd0, a3}, 32'd0);
      check_val("r0_wd3", wd3, 32'h12345678);
      check_val("r0_cnt1", {16'd0, grant_cnt1}, 32'd3);
      check_val("r0_prio", {31'd0, prio}, 32'd0);

      // Set prio to 1 before holding so the resumed grant is distinguishable
      req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h00000099;
      step();
      hold = 1'b1;
      req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h00000044;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val($sformatf("hold_ready0_%0d", i), {31'd0, req0_ready}, 32'd0);
         check_val($sformatf("hold_ready1_%0d", i), {31'd0, req1_ready}, 32'd0);
         step();
         check_val($sformatf("hold_we3_%0d", i), {31'd0, we3}, 32'd0);
         check_val($sformatf("hold_prio_%0d", i), {31'd0, prio}, 32'd1);
      end
      check_val("hold_cnt0", {16'd0, grant_cnt0}, 32'd4);
      check_val("hold_cnt1", {16'd0, grant_cnt1}, 32'd3);
      hold = 1'b0;
      #1;
      check_val("unhold_ready1", {31'd0, req1_ready}, 32'd1);
      check_val("unhold_ready0", {31'd0, req0_ready}, 32'd0);
      step();
      check_val("unhold_a3", {27'd0, a3}, 32'd4);
      check_val("unhold_we3", {31'd0, we3}, 32'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Saturation on the 2-bit instance
      reset = 1'b1;
      step();
      reset = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h00000066;
      for (int i = 0; i < 5; i++) begin
         step();
         check_val($sformatf("sat_cnt0_%0d", i), {30'd0, s_grant_cnt0}, (i < 3) ? (i + 1) : 32'd3);
      end
      req0_valid = 1'b0;
      check_val("sat_wide_cnt0", {16'd0, grant_cnt0}, 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
